// File: rtl/mem_dump_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump_serializer_pkg
//  Brief    : Shared constants, state encoding and byte-count helper for the
//             memory-dump serializer.
//             Optional feature macro: MEM_DUMP_CHECKSUM_EN
//  Revision : 1.0 - initial release
// ============================================================================
package mem_dump_serializer_pkg;

    localparam int IO_BUS_SIZE_DEF   = 32;
    localparam int MEM_ADDR_SIZE_DEF = 5;
    localparam int BYTE_SIZE         = 8;
    localparam int BYTES_PER_WORD    = IO_BUS_SIZE_DEF / BYTE_SIZE;

    // Explicit 2-bit state encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        CHECKSUM = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Number of bytes a complete dump puts on the transmit link
    function automatic int total_bytes(input int mem_addr_size, input int io_bus_size);
        int n;
        n = (1 << mem_addr_size) * (io_bus_size / BYTE_SIZE);
`ifdef MEM_DUMP_CHECKSUM_EN
        n = n + 1;
`endif
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dump_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump_serializer_if
//  Brief    : Groups the dump request, memory image and byte-stream handshake
//             of the memory-dump serializer.
//             master = serializer side, slave = requester / transmitter side.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_dump_serializer_if #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int BYTE_SIZE     = 8
);
    localparam int IMAGE_W = (2**MEM_ADDR_SIZE) * IO_BUS_SIZE;

    logic                 i_start;
    logic [IMAGE_W-1:0]   i_bus_debug;
    logic                 i_tx_ready;
    logic [BYTE_SIZE-1:0] o_tx_data;
    logic                 o_tx_valid;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        input  i_start,
        input  i_bus_debug,
        input  i_tx_ready,
        output o_tx_data,
        output o_tx_valid,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_start,
        output i_bus_debug,
        output i_tx_ready,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_busy,
        input  o_done
    );

endinterface
`default_nettype wire

// File: rtl/mem_dump_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dump_serializer
//  Brief    : Snapshots the flattened data-memory debug image on a start pulse
//             and streams it MSB-byte-first, word 0 upward, over a
//             valid/ready byte handshake.
//             Optional feature macro: MEM_DUMP_CHECKSUM_EN (appends an XOR
//             checksum byte after the image).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_dump_serializer #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int BYTE_SIZE     = mem_dump_serializer_pkg::BYTE_SIZE
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset,
    mem_dump_serializer_if.master  bus
);
    import mem_dump_serializer_pkg::*;

    localparam int c_BYTES_PER_WORD = IO_BUS_SIZE / BYTE_SIZE;
    localparam int c_WORDS          = 2**MEM_ADDR_SIZE;
    localparam int c_IMAGE_W        = c_WORDS * IO_BUS_SIZE;
    localparam int c_BIDX_W         = (c_BYTES_PER_WORD > 1) ? $clog2(c_BYTES_PER_WORD) : 1;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_IMAGE_W-1:0]     r_snapshot;
    logic [MEM_ADDR_SIZE-1:0] r_word_idx;
    logic [c_BIDX_W-1:0]      r_byte_idx;

    logic [IO_BUS_SIZE-1:0]   w_word;
    logic [BYTE_SIZE-1:0]     w_data_byte;
    logic [BYTE_SIZE-1:0]     w_tx_data;
    logic                     w_tx_valid;
    logic                     w_busy;
    logic                     w_done;
    logic                     w_capture;
    logic                     w_xfer;
    logic                     w_last_byte_of_word;
    logic                     w_last_word;

    assign w_capture           = (r_state == IDLE) && bus.i_start;
    assign w_xfer              = w_tx_valid && bus.i_tx_ready;
    assign w_last_byte_of_word = (r_byte_idx == c_BIDX_W'(c_BYTES_PER_WORD - 1));
    assign w_last_word         = (r_word_idx == MEM_ADDR_SIZE'(c_WORDS - 1));

    // State register; reset abandons any dump in flight
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Snapshot capture and word/byte index walk over the held image
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_snapshot <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
        end else if (w_capture) begin
            r_snapshot <= bus.i_bus_debug;
            r_word_idx <= '0;
            r_byte_idx <= '0;
        end else if ((r_state == SEND) && w_xfer) begin
            if (w_last_byte_of_word) begin
                r_byte_idx <= '0;
                r_word_idx <= r_word_idx + 1'b1;
            end else begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [BYTE_SIZE-1:0] r_checksum;

    // Running XOR of every image byte handed to the transmitter
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_checksum <= '0;
        end else if (w_capture) begin
            r_checksum <= '0;
        end else if ((r_state == SEND) && w_xfer) begin
            r_checksum <= r_checksum ^ w_data_byte;
        end
    end
`endif

    // Byte mux: pick the current word, then its byte with byte 0 = MSB
    always_comb begin
        w_word      = '0;
        w_data_byte = '0;
        for (int k = 0; k < c_WORDS; k++) begin
            if (r_word_idx == MEM_ADDR_SIZE'(k)) begin
                w_word = r_snapshot[k*IO_BUS_SIZE +: IO_BUS_SIZE];
            end
        end
        for (int b = 0; b < c_BYTES_PER_WORD; b++) begin
            if (r_byte_idx == c_BIDX_W'(b)) begin
                w_data_byte = w_word[(c_BYTES_PER_WORD-1-b)*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_next = r_state;
        w_tx_valid   = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_tx_data    = w_data_byte;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.i_start) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                w_tx_valid = 1'b1;
                if (w_xfer && w_last_word && w_last_byte_of_word) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    w_state_next = CHECKSUM;
`else
                    w_state_next = DONE;
`endif
                end
            end
            CHECKSUM: begin
`ifdef MEM_DUMP_CHECKSUM_EN
                w_tx_valid = 1'b1;
                w_tx_data  = r_checksum;
                if (w_xfer) begin
                    w_state_next = DONE;
                end
`else
                // Not reachable without the checksum feature
                w_state_next = IDLE;
`endif
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.o_tx_data  = w_tx_data;
    assign bus.o_tx_valid = w_tx_valid;
    assign bus.o_busy     = w_busy;
    assign bus.o_done     = w_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_dump_serializer
//  Brief    : Self-checking bench for mem_dump_serializer: table of directed
//             dumps plus randomized images and backpressure, compared with a
//             byte-queue reference model.
//             Optional feature macro: MEM_DUMP_CHECKSUM_EN
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dump_serializer;
    import mem_dump_serializer_pkg::*;

    localparam int NW    = 32;
    localparam int BPW   = 4;
    localparam int TOTAL = total_bytes(5, 32);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests  = 0;
    int   errors = 0;

    logic [31:0] img [NW];
    logic [7:0]  exp_q [$];

    mem_dump_serializer_if #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(5), .BYTE_SIZE(8)) bus ();

    mem_dump_serializer #(
        .IO_BUS_SIZE   (32),
        .MEM_ADDR_SIZE (5),
        .BYTE_SIZE     (8)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;       // 0 ramp pattern, 1 all ones, 2 only word0=1
        int         stall_at;   // byte index held under backpressure, -1 none
        int         stall_len;
        bit         poke;       // extra start pulses at byte 10 and on DONE
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_image(input int kind);
        for (int k = 0; k < NW; k++) begin
            case (kind)
                0:       img[k] = 32'h0A0B0C00 + k;
                1:       img[k] = 32'hFFFFFFFF;
                2:       img[k] = (k == 0) ? 32'h1 : 32'h0;
                default: img[k] = $urandom;
            endcase
        end
    endtask

    // Expected stream: words in order, bytes MSB first, optional XOR byte
    task automatic build_expected();
        logic [7:0]  cs;
        logic [31:0] v;
        exp_q.delete();
        cs = 8'h00;
        for (int k = 0; k < NW; k++) begin
            for (int b = 0; b < BPW; b++) begin
                v = img[k] >> (8 * (BPW - 1 - b));
                exp_q.push_back(v[7:0]);
                cs = cs ^ v[7:0];
            end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic load_image();
        for (int k = 0; k < NW; k++) begin
            bus.i_bus_debug[k*32 +: 32] = img[k];
        end
    endtask

    task automatic run_dump(input int stall_at, input int stall_len, input bit rand_ready,
                            input bit poke, output logic [7:0] first_b,
                            output logic [7:0] last_b, output int cycles);
        int idx;
        int cyc;
        int stall_cnt;
        bit poked;
        bit rdy;
        build_expected();
        first_b = 8'hxx;
        last_b  = 8'hxx;
        @(negedge clk);
        load_image();
        bus.i_start    = 1'b1;
        bus.i_tx_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.i_bus_debug = '1;
        @(negedge clk);
        bus.i_start = 1'b0;
        idx = 0; cyc = 0; stall_cnt = 0; poked = 1'b0;
        while (idx < TOTAL && cyc < TOTAL * 8 + 50) begin
            if (idx == stall_at && stall_cnt < stall_len) begin
                rdy = 1'b0;
                stall_cnt++;
            end else if (rand_ready) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            bus.i_tx_ready = rdy;
            bus.i_start    = poke && (idx == 10) && !poked;
            if (bus.i_start) poked = 1'b1;
            #1;
            check("send_flags", {29'd0, bus.o_tx_valid, bus.o_busy, bus.o_done}, 32'b110);
            check("send_data", {24'd0, bus.o_tx_data}, {24'd0, exp_q[idx]});
            if (idx == 0) first_b = bus.o_tx_data;
            if (rdy) begin
                last_b = bus.o_tx_data;
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        if (idx < TOTAL) check("byte_count_timeout", idx, TOTAL);
        bus.i_tx_ready = 1'b1;
        bus.i_start    = poke;
        #1;
        check("done_flags", {29'd0, bus.o_tx_valid, bus.o_busy, bus.o_done}, 32'b011);
        @(negedge clk);
        bus.i_start = 1'b0;
        #1;
        check("idle_flags", {29'd0, bus.o_tx_valid, bus.o_busy, bus.o_done}, 32'b000);
        cycles = cyc;
    endtask

    initial begin
        logic [7:0] fb;
        logic [7:0] lb;
        int         cyc;

`ifdef MEM_DUMP_CHECKSUM_EN
        vecs[0] = '{0, -1, 0, 1'b0, 8'h0A, 8'h00};
        vecs[1] = '{0,  3, 5, 1'b0, 8'h0A, 8'h00};
        vecs[2] = '{1, -1, 0, 1'b0, 8'hFF, 8'h00};
        vecs[3] = '{2, -1, 0, 1'b1, 8'h00, 8'h01};
`else
        vecs[0] = '{0, -1, 0, 1'b0, 8'h0A, 8'h1F};
        vecs[1] = '{0,  3, 5, 1'b0, 8'h0A, 8'h1F};
        vecs[2] = '{1, -1, 0, 1'b0, 8'hFF, 8'hFF};
        vecs[3] = '{2, -1, 0, 1'b1, 8'h00, 8'h00};
`endif

        bus.i_start     = 1'b0;
        bus.i_tx_ready  = 1'b0;
        bus.i_bus_debug = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {21'd0, bus.o_tx_data, bus.o_tx_valid, bus.o_busy, bus.o_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            fill_image(vecs[i].kind);
            run_dump(vecs[i].stall_at, vecs[i].stall_len, 1'b0, vecs[i].poke, fb, lb, cyc);
            check("first_byte", {24'd0, fb}, {24'd0, vecs[i].exp_first});
            check("last_byte", {24'd0, lb}, {24'd0, vecs[i].exp_last});
            check("throughput_cycles", cyc, TOTAL + vecs[i].stall_len);
        end

        // Random images with random backpressure
        for (int r = 0; r < 6; r++) begin
            fill_image(3);
            run_dump(-1, 0, 1'b1, 1'b0, fb, lb, cyc);
        end

        // Reset in the middle of a dump
        fill_image(0);
        @(negedge clk);
        load_image();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_tx_ready = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        check("mid_dump_busy", {31'd0, bus.o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {21'd0, bus.o_tx_data, bus.o_tx_valid, bus.o_busy, bus.o_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(-1, 0, 1'b0, 1'b0, fb, lb, cyc);
        check("restart_first_byte", {24'd0, fb}, 32'h0A);
        check("restart_cycles", cyc, TOTAL);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
